skid_mreg: RTL and testbench
============================

SKID_MREG -- requirements
Module: skid_mreg

Interface
REQ-001 The block SHALL have parameter `width`, default 1, giving the data width in bits.
REQ-002 The block SHALL have the following ports:
- clk  input  1  — sole clock; all state updates on its rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- in_valid  input  1  — upstream presents a word.
- in_ready  output  1  — block can accept a word this cycle.
- in_sel  input  1  — selects in_d1 (1) or in_d0 (0) as the word accepted.
- in_d1  input  width  — data candidate 1.
- in_d0  input  width  — data candidate 0.
- out_valid  output  1  — out_q holds a valid word.
- out_ready  input  1  — downstream consumes out_q this cycle.
- out_q  output  width  — head word.
- stall_cnt  output  16  — stall counter; present only under SKID_MREG_STATS_EN.

Function
REQ-003 An upstream transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; the word captured SHALL be (in_sel ? in_d1 : in_d0).
REQ-004 A downstream transfer SHALL occur on a rising clk edge where out_valid=1 and out_ready=1.
REQ-005 Storage SHALL be two width-bit registers: main, which drives out_q, and skid.
REQ-006 The state machine SHALL have three states:
- EMPTY — no words held.
- ONE — main valid, skid empty.
- FULL — main and skid both valid.
REQ-007 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-008 in_ready SHALL be 1 exactly in EMPTY and ONE, decoded directly from state flops with no combinational path from out_ready.
REQ-009 EMPTY transitions:
- accept → ONE, with main = word.
- no accept → stay in EMPTY.
REQ-010 ONE transitions:
- accept and consume → stay in ONE, with main = word.
- accept only → FULL, with skid = word.
- consume only → EMPTY.
- neither → stay in ONE.
REQ-011 FULL transitions:
- consume → ONE, with main = skid.
- no consume → stay in FULL, all registers held.
- No accept is possible in FULL.
REQ-012 Words SHALL leave in arrival order; none SHALL be duplicated or dropped.
REQ-013 Latency from accept to out_valid SHALL be one cycle when the block is EMPTY.
REQ-014 Sustained throughput SHALL be one word per cycle while out_ready=1.
REQ-015 Registers not written in a cycle SHALL hold their value (enable-register behaviour).
REQ-016 The skid register SHALL be written only on the ONE→FULL transition.
REQ-017 Data outputs SHALL NOT depend on in_valid or in_sel when no accept occurs.
REQ-018 When out_valid=0, the value of out_q is don't-care for consumers but SHALL still be deterministic (the last main value).

Reset
REQ-019 rst_n=0 SHALL, asynchronously and without waiting for clk, force:
- state to EMPTY;
- main and skid to 0;
- out_valid to 0 and in_ready to 1;
- stall_cnt to 0 when present.
REQ-020 Reset assertion mid-transfer SHALL discard all held words.
REQ-021 Reset deassertion SHALL take effect at the first rising clk edge after rst_n=1; no transfer SHALL be lost or invented on that edge beyond REQ-003/REQ-004.

Configuration
REQ-022 Macro SKID_MREG_STATS_EN SHALL control the stall counter.
REQ-023 With SKID_MREG_STATS_EN defined, stall_cnt SHALL behave as follows:
- It increments by 1 on each rising clk edge where out_valid=1 and out_ready=0.
- It saturates at 16'hFFFF.
- It is reset only by rst_n.
REQ-024 With SKID_MREG_STATS_EN undefined, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (width=4)
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset then idle: rst_n low, out_ready=1 → out_valid=0, in_ready=1, out_q=4'h0.
- Single word: in_valid=1, in_sel=1, in_d1=4'hA, in_d0=4'h5 for one cycle → next cycle out_valid=1, out_q=4'hA.
- Fill: out_ready=0, send 4'h3 then 4'h7 → in_ready=0 after the second accept.
  - Raise out_ready → out_q=4'h3, then 4'h7, then out_valid=0.
- Streaming: out_ready=1, in_valid=1, words 1..8 on consecutive cycles → out_q=1..8 on consecutive cycles; in_ready stays 1.
- Async reset mid-operation: in FULL, drop rst_n between clk edges → out_valid=0 and in_ready=1 immediately; held words never appear.
- Stats (macro defined): out_valid=1, out_ready=0 for 5 edges → stall_cnt=5.
  - Forced 16'hFFFF plus one more stall edge → stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/skid_mreg.sv
// skid_mreg: two-entry skid buffer (main + skid registers) with a muxed input word.
// Define SKID_MREG_STATS_EN to add the saturating stall_cnt output.
module skid_mreg #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [width-1:0] in_d1,
    input  logic [width-1:0] in_d0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_q
`ifdef SKID_MREG_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] main_r;
    logic [width-1:0] skid_r;
    logic [width-1:0] word;
    logic             accept;
    logic             consume;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

    // Handshake flags come straight off the state register, so in_ready has
    // no combinational path from out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_q     = main_r;

    assign word    = in_sel ? in_d1 : in_d0;
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_nxt      = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // NOTE: the two data registers are reset as well, so out_q is a known
    // 0 straight out of reset rather than whatever the flops powered up to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (main_load) begin
                main_r <= main_from_skid ? skid_r : word;
            end
            if (skid_load) begin
                skid_r <= word;
            end
        end
    end

`ifdef SKID_MREG_STATS_EN
    // Counts edges where a valid head word was held back by downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_skid_mreg.sv
// Self-checking bench for skid_mreg (width=4): directed scenarios plus random
// traffic against a two-deep FIFO reference model.
module tb_skid_mreg;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_sel    = 1'b0;
    logic [W-1:0] in_d1     = '0;
    logic [W-1:0] in_d0     = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_q;
`ifdef SKID_MREG_STATS_EN
    logic [15:0]  stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue holding at most two words, plus the last head.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    int unsigned  m_stall;

    always #5 clk = ~clk;

    skid_mreg #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_d1     (in_d1),
        .in_d0     (in_d0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q)
`ifdef SKID_MREG_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time bound (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
    endtask

    // One clock: update the model with the inputs present at the edge,
    // then return on the following falling edge for checking and driving.
    task automatic step();
        bit acc;
        bit con;
        @(posedge clk);
        acc = in_valid && (mq.size() < 2);
        con = (mq.size() > 0) && out_ready;
        if ((mq.size() > 0) && !out_ready && (m_stall < 32'hFFFF)) m_stall++;
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(in_sel ? in_d1 : in_d0);
        if (mq.size() > 0) m_last = mq[0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #23;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_q !== 4'h0) begin
            n_bad++; $display("FAIL reset_out_q: got %h want 0", out_q);
        end
`ifdef SKID_MREG_STATS_EN
        n_cmp++;
        if (stall_cnt !== 16'h0) begin
            n_bad++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 1'b1;
        in_d1     = 4'hA;
        in_d0     = 4'h5;
        step();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_q !== 4'hA) begin
            n_bad++; $display("FAIL single_word: got v=%b q=%h want v=1 q=a", out_valid, out_q);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_q !== 4'hA) begin
            n_bad++; $display("FAIL single_drain: got v=%b q=%h want v=0 q=a", out_valid, out_q);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 1'b0;
        in_d1     = 4'hE;
        in_d0     = 4'h3;
        step();
        in_d0 = 4'h7;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_q !== 4'h3) begin
            n_bad++;
            $display("FAIL fill_full: got rdy=%b v=%b q=%h want rdy=0 v=1 q=3", in_ready, out_valid, out_q);
        end
        // A held in_valid while FULL must not be taken.
        in_valid = 1'b1;
        in_d0    = 4'hC;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_q !== 4'h3) begin
            n_bad++; $display("FAIL fill_hold: got rdy=%b q=%h want rdy=0 q=3", in_ready, out_q);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_q !== 4'h7 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL fill_second: got v=%b q=%h rdy=%b want v=1 q=7 rdy=1", out_valid, out_q, in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL fill_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            logic [W-1:0] w;
            w        = W'(i);
            in_valid = 1'b1;
            in_sel   = 1'($urandom_range(0, 1));
            in_d1    = in_sel ? w : W'($urandom);
            in_d0    = in_sel ? W'($urandom) : w;
            step();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_q !== w) begin
                n_bad++;
                $display("FAIL stream_%0d: got rdy=%b v=%b q=%h want rdy=1 v=1 q=%h", i, in_ready, out_valid, out_q, w);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL stream_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 1'b1;
        in_d1     = 4'h9;
        step();
        in_d1 = 4'hB;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL areset_pre_full: got rdy=%b want 0", in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q !== 4'h0) begin
            n_bad++;
            $display("FAIL areset_immediate: got v=%b rdy=%b q=%h want v=0 rdy=1 q=0", out_valid, in_ready, out_q);
        end
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL areset_ghost_%0d: got v=%b q=%h want v=0", i, out_valid, out_q);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 1'($urandom_range(0, 1));
            in_d1     = W'($urandom);
            in_d0     = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            n_cmp++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                out_q !== ((mq.size() > 0) ? mq[0] : m_last)) begin
                n_bad++;
                $display("FAIL random_%0d: got v=%b rdy=%b q=%h want v=%b rdy=%b q=%h", i,
                         out_valid, in_ready, out_q, (mq.size() > 0), (mq.size() < 2),
                         (mq.size() > 0) ? mq[0] : m_last);
            end
`ifdef SKID_MREG_STATS_EN
            n_cmp++;
            if (stall_cnt !== 16'(m_stall)) begin
                n_bad++; $display("FAIL random_stall_%0d: got %0d want %0d", i, stall_cnt, m_stall);
            end
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

`ifdef SKID_MREG_STATS_EN
    task automatic test_stats();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 1'b0;
        in_d0     = 4'h6;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++; $display("FAIL stats_five: got %0d want 5", stall_cnt);
        end
        for (int i = 0; i < 65530; i++) step();
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_bad++; $display("FAIL stats_reach_max: got %h want ffff", stall_cnt);
        end
        step();
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_bad++; $display("FAIL stats_saturate: got %h want ffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_async_reset();
        test_random();
`ifdef SKID_MREG_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
